// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: pattern/digit types, the digit->pattern table,
// receiver FSM states and the pattern decoder used by the segment receiver.
package seg_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 3;
  localparam int unsigned N_DIGIT = 8;

  typedef logic [SEG_W-1:0]   seg_pat_t;
  typedef logic [DIGIT_W-1:0] seg_digit_t;

  localparam seg_pat_t SEG_BLANK = 7'h00;

  // Index is the digit; bit0=a .. bit6=g, active-high.
  localparam seg_pat_t SEG_LUT [N_DIGIT] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
  };

  typedef enum logic {
    ACQ  = 1'b0,
    LOCK = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    seg_digit_t digit;
  } seg_dec_t;

  // Reverse lookup; legal and blank are mutually exclusive, both clear means illegal.
  function automatic seg_dec_t seg_to_digit(input seg_pat_t pat);
    seg_dec_t res;
    res       = '0;
    res.blank = (pat == SEG_BLANK);
    for (int i = 0; i < int'(N_DIGIT); i++) begin
      if (pat == SEG_LUT[i]) begin
        res.legal = 1'b1;
        res.digit = DIGIT_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_stab_filter.sv
// Stability filter: samples a bus every cycle and pulses qualify_c on the edge
// where the value has held for STABLE_CYCLES further samples (1..15).
module seg_stab_filter #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned WIDTH         = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic             change_c,
  output logic             qualify_c
`ifdef SEG_GLITCH_CNT_EN
  ,
  output logic             abandon_c
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] pat_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign change_c  = (d_i != pat_q);
  assign qualify_c = !change_c && (cnt_q == (CNT_MAX - CNT_W'(1)));
`ifdef SEG_GLITCH_CNT_EN
  assign abandon_c = change_c && (cnt_q != '0);
`endif

  // Saturating run counter of matching samples.
  always_comb begin
    cnt_d = cnt_q;
    if (change_c) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= d_i;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_decode_rx.sv
// Segment-bus receiver: recovers digits 0-7 from a stable 7-segment pattern,
// flags blank and illegal patterns. SEG_GLITCH_CNT_EN adds glitch_cnt.
module seg_decode_rx
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned ERRCNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  seg_pat_t            seg_pat,
  output seg_digit_t          digit,
  output logic                digit_valid,
  output logic                blank,
  output logic                locked,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt
`ifdef SEG_GLITCH_CNT_EN
  ,
  output logic [ERRCNT_W-1:0] glitch_cnt
`endif
);

  rx_state_t           state_q, state_d;
  seg_digit_t          digit_q, digit_d;
  logic                digit_valid_q, digit_valid_d;
  logic                blank_q, blank_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic     change_c;
  logic     qualify_c;
  seg_dec_t dec_c;

`ifdef SEG_GLITCH_CNT_EN
  logic                abandon_c;
  logic [ERRCNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
`endif

  seg_stab_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .WIDTH         (SEG_W)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .d_i       (seg_pat),
    .change_c  (change_c),
    .qualify_c (qualify_c)
`ifdef SEG_GLITCH_CNT_EN
    ,
    .abandon_c (abandon_c)
`endif
  );

  // On the qualifying edge seg_pat equals the sampled pattern.
  assign dec_c = seg_to_digit(seg_pat);

  // Next-state and qualification actions.
  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    blank_d       = blank_q;
    err_d         = 1'b0;
    err_cnt_d     = err_cnt_q;
    case (state_q)
      ACQ: begin
        if (qualify_c) begin
          state_d = LOCK;
          if (dec_c.legal) begin
            digit_d       = dec_c.digit;
            digit_valid_d = 1'b1;
            blank_d       = 1'b0;
          end else if (dec_c.blank) begin
            blank_d = 1'b1;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERRCNT_W'(1);
            end
          end
        end
      end
      LOCK: begin
        if (change_c) begin
          state_d = ACQ;
        end
      end
      default: state_d = ACQ;
    endcase
    locked_d = (state_d == LOCK);
  end

`ifdef SEG_GLITCH_CNT_EN
  // Patterns dropped mid-acquisition; exits from LOCK are not glitches.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if ((state_q == ACQ) && abandon_c && (glitch_cnt_q != '1)) begin
      glitch_cnt_d = glitch_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACQ;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      blank_q       <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      blank_q       <= blank_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign blank       = blank_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg_decode_rx.sv
// Bench for seg_decode_rx: run-length reference model feeding a scoreboard,
// a table of hold sequences with hand-derived end states, and reset corner cases.
module tb_seg_decode_rx;

  localparam int S = 2;
  localparam int EW = 8;

  logic          clk;
  logic          rst;
  logic [6:0]    seg_pat;
  logic [2:0]    digit;
  logic          digit_valid;
  logic          blank;
  logic          locked;
  logic          err;
  logic [EW-1:0] err_cnt;
`ifdef SEG_GLITCH_CNT_EN
  logic [EW-1:0] glitch_cnt;
`endif

  seg_decode_rx #(
    .STABLE_CYCLES (S),
    .ERRCNT_W      (EW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_pat     (seg_pat),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .locked      (locked),
    .err         (err),
    .err_cnt     (err_cnt)
`ifdef SEG_GLITCH_CNT_EN
    ,
    .glitch_cnt  (glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] digit;
    logic       dv;
    logic       blank;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] glitch;
  } obs_t;

  typedef struct {
    logic [6:0] pat;
    int         hold;
    logic [2:0] digit;
    logic       blank;
    logic       locked;
    int         n_valid;
    int         n_err;
    logic [7:0] err_cnt;
    int         n_unlocked;
  } vec_t;

  localparam int NV = 9;
  vec_t       vecs [NV];
  logic [6:0] lut  [8];
  obs_t       exp_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: run length of the current sample value.
  logic [6:0] m_prev;
  int         m_run;
  obs_t       m;

  function automatic obs_t sample();
    obs_t o;
    o.digit   = digit;
    o.dv      = digit_valid;
    o.blank   = blank;
    o.locked  = locked;
    o.err     = err;
    o.err_cnt = err_cnt;
`ifdef SEG_GLITCH_CNT_EN
    o.glitch  = glitch_cnt;
`else
    o.glitch  = 8'h00;
`endif
    return o;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, required %0d", name, idx, act, req);
    end
  endtask

  task automatic model_reset();
    m_prev = 7'h00;
    m_run  = 1;
    m      = '0;
  endtask

  task automatic model_edge(input logic [6:0] pat);
    int old;
    int idx;
    old    = m_run;
    m.dv   = 1'b0;
    m.err  = 1'b0;
    if (pat == m_prev) begin
      if (m_run < S + 1) m_run++;
    end else begin
`ifdef SEG_GLITCH_CNT_EN
      if (old >= 2 && old <= S && m.glitch != 8'hFF) m.glitch = m.glitch + 8'd1;
`endif
      m_run = 1;
    end
    m_prev   = pat;
    m.locked = (m_run == S + 1);
    if (m_run == S + 1 && old == S) begin
      idx = -1;
      for (int i = 0; i < 8; i++) if (lut[i] == pat) idx = i;
      if (idx >= 0) begin
        m.dv    = 1'b1;
        m.digit = 3'(idx);
        m.blank = 1'b0;
      end else if (pat == 7'h00) begin
        m.blank = 1'b1;
      end else begin
        m.err = 1'b1;
        if (m.err_cnt != 8'hFF) m.err_cnt = m.err_cnt + 8'd1;
      end
    end
  endtask

  // One clock: drive at negedge, push model result, compare after posedge.
  task automatic step(input logic [6:0] pat);
    obs_t a;
    obs_t e;
    @(negedge clk);
    seg_pat = pat;
    model_edge(pat);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    cyc++;
    a = sample();
    e = exp_q.pop_front();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL sb cycle %0d pat=%h: got %h, required %h", cyc, pat, a, e);
    end
  endtask

  task automatic pulse_reset(input string name);
    #2;
    rst = 1'b1;
    #1;
    chk({name, " async clear"}, 0, int'(sample()), 0);
    @(posedge clk);
    #2;
    chk({name, " held clear"}, 0, int'(sample()), 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic latency_check(input string name, input logic [6:0] pat, input int dgt);
    int lat;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      if (lat == 0) begin
        step(pat);
        if (digit_valid) lat = k;
      end
    end
    chk({name, " latency"}, 0, lat, 3);
    chk({name, " digit"}, 0, int'(digit), dgt);
  endtask

  initial begin
    int nv;
    int ne;
    int nu;

    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
    //           pat    hold digit blank lock nv ne errcnt unlocked
    vecs[0] = '{7'h5B, 5, 3'd2, 1'b0, 1'b1, 1, 0, 8'd0, 2};
    vecs[1] = '{7'h06, 2, 3'd2, 1'b0, 1'b0, 0, 0, 8'd0, 2};
    vecs[2] = '{7'h4F, 4, 3'd3, 1'b0, 1'b1, 1, 0, 8'd0, 2};
    vecs[3] = '{7'h00, 4, 3'd3, 1'b1, 1'b1, 0, 0, 8'd0, 2};
    vecs[4] = '{7'h07, 4, 3'd7, 1'b0, 1'b1, 1, 0, 8'd0, 2};
    vecs[5] = '{7'h7F, 4, 3'd7, 1'b0, 1'b1, 0, 1, 8'd1, 2};
    vecs[6] = '{7'h6D, 5, 3'd5, 1'b0, 1'b1, 1, 0, 8'd1, 2};
    vecs[7] = '{7'h6C, 1, 3'd5, 1'b0, 1'b0, 0, 0, 8'd1, 1};
    vecs[8] = '{7'h6D, 5, 3'd5, 1'b0, 1'b1, 1, 0, 8'd1, 2};

    rst     = 1'b1;
    seg_pat = 7'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset state", 0, int'(sample()), 0);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      nv = 0; ne = 0; nu = 0;
      for (int c = 0; c < vecs[v].hold; c++) begin
        step(vecs[v].pat);
        nv += int'(digit_valid);
        ne += int'(err);
        nu += int'(!locked);
      end
      chk("vec digit",    v, int'(digit),   int'(vecs[v].digit));
      chk("vec blank",    v, int'(blank),   int'(vecs[v].blank));
      chk("vec locked",   v, int'(locked),  int'(vecs[v].locked));
      chk("vec valid",    v, nv,            vecs[v].n_valid);
      chk("vec err",      v, ne,            vecs[v].n_err);
      chk("vec err_cnt",  v, int'(err_cnt), int'(vecs[v].err_cnt));
      chk("vec unlocked", v, nu,            vecs[v].n_unlocked);
    end
`ifdef SEG_GLITCH_CNT_EN
    chk("glitch after table", 0, int'(glitch_cnt), 1);
`endif

    // Illegal/blank alternation drives err_cnt into saturation.
    nv = 0; ne = 0;
    for (int r = 0; r < 300; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(7'h7F);
        ne += int'(err);
        nv += int'(digit_valid);
      end
      for (int c = 0; c < 4; c++) begin
        step(7'h00);
        ne += int'(err);
        nv += int'(digit_valid);
      end
    end
    chk("sat err pulses", 0, ne, 300);
    chk("sat err_cnt", 0, int'(err_cnt), 255);
    chk("sat no valid", 0, nv, 0);
    chk("sat blank", 0, int'(blank), 1);
    chk("sat digit held", 0, int'(digit), 5);

    // Reset mid-acquisition, then while locked on an unchanged bus.
    step(7'h66);
    chk("pre-rst locked", 0, int'(locked), 0);
    pulse_reset("rst_acq");
    latency_check("rst_acq", 7'h66, 4);
    step(7'h66);
    step(7'h66);
    chk("pre-rst2 locked", 0, int'(locked), 1);
    pulse_reset("rst_lock");
    latency_check("rst_lock", 7'h66, 4);

    // Locked pattern held long: no re-report.
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      step(7'h66);
      nv += int'(digit_valid);
    end
    chk("hold no rereport", 0, nv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
